// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle add/subtract unit with registered NZCV flags.
// The operands are processed SLICE bits per clock, starting with the LSB slice.
// The carry is chained from one cycle to the next.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid/in_ready    operand handshake (opA, opB, sel)
//   out_valid/out_ready  result handshake (res, z, c, v, n, err)
//   sel                  000 ADD, 001 SUB, 010 RSB (B-A), 011 CMP; others illegal
//
// state | meaning
// IDLE  | waiting for an operation, in_ready=1
// CALC  | one slice per clock, slice counter counts 0..N-1
// ERR   | illegal sel accepted; one-cycle turnaround before DONE
// DONE  | res/flags held, out_valid=1 until out_ready
module serial_addsub #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             z,
  output logic             c,
  output logic             v,
  output logic             n,
  output logic             err
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, ERR, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] x_sh, y_sh;
  logic             carry;
  logic             zacc;
  logic             is_cmp;
  logic [SLICE:0]   sum;
  logic             legal;
  logic             last;

  assign legal = (sel[2] == 1'b0);
  assign last  = (cnt == CW'(N - 1));

  // x_sh/y_sh shift right every CALC cycle, so the active slice is always
  // in the low SLICE bits.
  assign sum = {1'b0, x_sh[SLICE-1:0]} + {1'b0, y_sh[SLICE-1:0]} + {{SLICE{1'b0}}, carry};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = legal ? CALC : ERR;
      end
      CALC: if (last) state_nxt = DONE;
      ERR:  state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      x_sh   <= '0;
      y_sh   <= '0;
      carry  <= 1'b0;
      zacc   <= 1'b0;
      is_cmp <= 1'b0;
      res    <= '0;
      z      <= 1'b0;
      c      <= 1'b0;
      v      <= 1'b0;
      n      <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt    <= '0;
            zacc   <= 1'b1;
            is_cmp <= (sel == 3'b011);
            if (legal) err <= 1'b0;
            case (sel)
              3'b000: begin
                x_sh  <= opA;
                y_sh  <= opB;
                carry <= 1'b0;
              end
              3'b001, 3'b011: begin
                x_sh  <= opA;
                y_sh  <= ~opB;
                carry <= 1'b1;
              end
              3'b010: begin
                x_sh  <= opB;
                y_sh  <= ~opA;
                carry <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          x_sh  <= x_sh >> SLICE;
          y_sh  <= y_sh >> SLICE;
          carry <= sum[SLICE];
          zacc  <= zacc & (sum[SLICE-1:0] == '0);
          if (!is_cmp) begin
            for (int k = 0; k < N; k++)
              if (cnt == CW'(k)) res[k*SLICE +: SLICE] <= sum[SLICE-1:0];
          end
          if (last) begin
            // On the final slice, the low bits of x_sh/y_sh hold the operand MSB slice.
            c <= sum[SLICE];
            z <= zacc & (sum[SLICE-1:0] == '0);
            n <= sum[SLICE-1];
            v <= (x_sh[SLICE-1] == y_sh[SLICE-1]) && (sum[SLICE-1] != x_sh[SLICE-1]);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ERR: begin
          res <= '0;
          z   <= 1'b0;
          c   <= 1'b0;
          v   <= 1'b0;
          n   <= 1'b0;
          err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] opA, opB;
  logic [2:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        z, c, v, n, err;
  logic [3:0]  flags;

  int checks   = 0;
  int failures = 0;

  assign flags = {z, c, v, n};

  serial_addsub #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opA(opA), .opB(opB), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .z(z), .c(c), .v(v), .n(n), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, measure accept-to-out_valid latency, check the
  // result and optionally hand it off with out_ready.
  task automatic run_op(input string tag, input logic [2:0] s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic [3:0] exp_flags, input logic exp_err,
                        input int exp_lat, input bit release_out);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready_idle"}, in_ready, 1);
    opA = a; opB = b; sel = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    opA = $urandom; opB = $urandom; sel = 3'($urandom);
    lat = 0;
    if (exp_lat > 1) check({tag, "_in_ready_busy"}, in_ready, 0);
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_res"}, res, exp_res);
    check({tag, "_flags_zcvn"}, flags, exp_flags);
    check({tag, "_err"}, err, exp_err);
    if (release_out) begin
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_out_valid_clr"}, out_valid, 0);
      check({tag, "_in_ready_back"}, in_ready, 1);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opA = '0; opB = '0; sel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_res", res, 0);
    check("rst_flags", flags, 0);
    check("rst_err", err, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    run_op("sub_5_3",    3'b001, 32'd5,          32'd3, 32'h0000_0002, 4'b0100, 1'b0, 4, 1);
    run_op("sub_3_5",    3'b001, 32'd3,          32'd5, 32'hFFFF_FFFE, 4'b0001, 1'b0, 4, 1);
    run_op("add_ovf",    3'b000, 32'h7FFF_FFFF,  32'd1, 32'h8000_0000, 4'b0011, 1'b0, 4, 1);
    run_op("add_wrap",   3'b000, 32'hFFFF_FFFF,  32'd1, 32'h0000_0000, 4'b1100, 1'b0, 4, 1);
    run_op("sub_ovf",    3'b001, 32'h8000_0000,  32'd1, 32'h7FFF_FFFF, 4'b0110, 1'b0, 4, 1);
    run_op("rsb_3_5",    3'b010, 32'd3,          32'd5, 32'h0000_0002, 4'b0100, 1'b0, 4, 1);
    run_op("sub_9_4",    3'b001, 32'd9,          32'd4, 32'h0000_0005, 4'b0100, 1'b0, 4, 1);
    run_op("cmp_7_7",    3'b011, 32'd7,          32'd7, 32'h0000_0005, 4'b1100, 1'b0, 4, 1);
    run_op("illegal",    3'b111, 32'h1234,       32'h55, 32'h0000_0000, 4'b0000, 1'b1, 1, 1);

    // Result held in DONE while out_ready stays low; in_valid is ignored.
    run_op("hold", 3'b000, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 4'b0000, 1'b0, 4, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      opA = 32'hDEAD_0000 + i; opB = 32'h1; sel = 3'b001;
      @(posedge clk); #1;
      check("hold_res", res, 32'h2345_6789);
      check("hold_flags", flags, 4'b0000);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hold_release_out_valid", out_valid, 0);
    check("hold_release_in_ready", in_ready, 1);
    check("hold_release_res", res, 32'h2345_6789);

    // Reset asserted while slice 2 would compute.
    @(negedge clk);
    opA = 32'hFFFF_FFFF; opB = 32'hFFFF_FFFF; sel = 3'b000; in_valid = 1'b1;
    @(posedge clk); #1;             // accept edge
    in_valid = 1'b0;
    @(posedge clk); #1;             // slice 0
    @(posedge clk); #1;             // slice 1
    check("midrst_busy", in_ready, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_res", res, 0);
    check("midrst_flags", flags, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_still_idle", out_valid, 0);
    run_op("post_rst_add", 3'b000, 32'd1, 32'd1, 32'h0000_0002, 4'b0000, 1'b0, 4, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
